// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The encoder uses the slave view and its feeder/consumer use the master view.
interface instr_encoder_if #(
  parameter int AW = 10
);
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    fmt;
  logic [6:0]    opcode;
  logic [4:0]    rd;
  logic [4:0]    rs1;
  logic [4:0]    rs2;
  logic [2:0]    funct3;
  logic [6:0]    funct7;
  logic [31:0]   imm;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_addr;
  logic          err_pulse;
  logic [7:0]    err_count;

  modport master (
    output clear, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, err_pulse, err_count
  );

  modport slave (
    input  clear, in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, err_pulse, err_count
  );
endinterface

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: swizzles the immediate per format, rejects out-of-range
// immediates, and queues legal words in a small FIFO with a running word address.
module instr_encoder #(
  parameter int DEPTH     = 2,
  parameter int AW        = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic           clk,
  input  logic           n_rst,
  instr_encoder_if.slave bus
);
  localparam int              PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0]   BASE = AW'(BASE_ADDR);
  localparam logic [PW:0]     FULL = (PW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   cnt;
  logic [AW-1:0] addr;
  logic          err_q;
  logic [7:0]    err_cnt;

  logic [31:0] word;
  logic        rej, acc, push, pop;
  logic        sx12, sx13, sx21;

  // An immediate fits N signed bits when everything from bit N-1 upward is a copy of one bit.
  assign sx12 = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
  assign sx13 = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
  assign sx21 = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);

  always_comb begin
    word = '0;
    rej  = 1'b0;
    case (bus.fmt)
      3'd0: word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: begin
        word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        rej  = ~sx12;
      end
      3'd2: begin
        word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
        rej  = ~sx12;
      end
      3'd3: begin
        word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                bus.imm[4:1], bus.imm[11], bus.opcode};
        rej  = ~sx13 | bus.imm[0];
      end
      3'd4: begin
        word = {bus.imm[31:12], bus.rd, bus.opcode};
        rej  = |bus.imm[11:0];
      end
      3'd5: begin
        word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd, bus.opcode};
        rej  = ~sx21 | bus.imm[0];
      end
      default: rej = 1'b1;
    endcase
  end

  // No pass-through: a full FIFO refuses even when the head pops this cycle.
  assign bus.in_ready  = (cnt != FULL);
  assign bus.out_valid = |cnt;
  assign bus.out_instr = mem[rd_ptr];
  assign bus.out_addr  = addr;
  assign bus.err_pulse = err_q;
  assign bus.err_count = err_cnt;

  assign acc  = bus.in_valid & bus.in_ready & ~bus.clear;
  assign push = acc & ~rej;
  assign pop  = bus.out_valid & bus.out_ready & ~bus.clear;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      addr    <= BASE;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else if (bus.clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      addr    <= BASE;
      err_q   <= 1'b0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= word;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
        addr   <= addr + AW'(1);
      end
      cnt   <= cnt + (PW+1)'(push) - (PW+1)'(pop);
      err_q <= acc & rej;
      if (acc && rej && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: directed RV32I vectors, backpressure, rejects,
// address wrap, clear and async reset, then randomized traffic against a reference model.
module tb_instr_encoder;
  localparam int DEPTH = 2;
  localparam int AW    = 2;

  typedef struct { logic [31:0] instr; logic [AW-1:0] addr; } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  instr_encoder_if #(.AW(AW)) bus();
  instr_encoder #(.DEPTH(DEPTH), .AW(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   m_cnt = 0;
  int   m_idx = 0;
  int   m_errc = 0;
  logic m_err = 1'b0;
  logic rdone = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_enc(input logic [31:0] f, op, rd, rs1, rs2, f3, f7, imm);
    case (f)
      0: return op | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25;
      1: return op | rd << 7 | f3 << 12 | rs1 << 15 | (imm & 32'hFFF) << 20;
      2: return op | (imm & 31) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | ((imm >> 5) & 127) << 25;
      3: return op | ((imm >> 11) & 1) << 7 | ((imm >> 1) & 15) << 8 | f3 << 12 | rs1 << 15
                | rs2 << 20 | ((imm >> 5) & 63) << 25 | ((imm >> 12) & 1) << 31;
      4: return op | rd << 7 | (imm & 32'hFFFFF000);
      default: return op | rd << 7 | ((imm >> 12) & 255) << 12 | ((imm >> 11) & 1) << 20
                | ((imm >> 1) & 1023) << 21 | ((imm >> 20) & 1) << 31;
    endcase
  endfunction

  function automatic bit ref_rej(input logic [2:0] f, input logic [31:0] imm);
    int s;
    s = $signed(imm);
    case (f)
      3'd0:        return 1'b0;
      3'd1, 3'd2:  return (s < -2048 || s > 2047);
      3'd3:        return (s < -4096 || s > 4095 || imm[0]);
      3'd4:        return (imm % 4096) != 0;
      3'd5:        return (s < -(1 << 20) || s > (1 << 20) - 1 || imm[0]);
      default:     return 1'b1;
    endcase
  endfunction

  // Reference model: occupancy, error status and expected-word queue.
  always @(negedge clk) begin
    if (!n_rst) begin
      m_cnt = 0; m_idx = 0; m_errc = 0; m_err = 1'b0;
      exp_q.delete();
    end else begin
      bit acc, rj, pop;
      chk("in_ready", bus.in_ready, m_cnt < DEPTH);
      chk("out_valid", bus.out_valid, m_cnt != 0);
      chk("err_pulse", bus.err_pulse, m_err);
      chk("err_count", bus.err_count, m_errc);
      if (bus.clear) begin
        m_cnt = 0; m_idx = 0; m_errc = 0; m_err = 1'b0;
        exp_q.delete();
      end else begin
        pop = (m_cnt > 0) && bus.out_ready;
        acc = bus.in_valid && (m_cnt < DEPTH);
        rj  = ref_rej(bus.fmt, bus.imm);
        m_err = acc && rj;
        if (acc && rj && m_errc < 255) m_errc++;
        if (acc && !rj) begin
          exp_q.push_back('{ref_enc(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2,
                                    bus.funct3, bus.funct7, bus.imm), AW'(m_idx)});
          m_idx++;
          m_cnt++;
        end
        if (pop) m_cnt--;
      end
    end
  end

  // Monitor: compare the head against the scoreboard whenever the DUT presents one.
  always @(negedge clk) begin
    if (n_rst && !bus.clear && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_out: got %h want nothing", bus.out_instr);
      end else begin
        chk("out_instr", bus.out_instr, exp_q[0].instr);
        chk("out_addr", 32'(bus.out_addr), 32'(exp_q[0].addr));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d, s1, s2,
                      input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
    int n;
    bus.fmt = f; bus.opcode = op; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2;
    bus.funct3 = f3; bus.funct7 = f7; bus.imm = im; bus.in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    if (!bus.in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: in_ready stuck at 0 after %0d cycles, want 1", n);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic clr(input bit with_req);
    if (with_req) begin
      bus.fmt = 3'd1; bus.opcode = 7'h13; bus.rd = 5'd3; bus.imm = 32'd1; bus.in_valid = 1'b1;
    end
    bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("clr_out_valid", bus.out_valid, 0);
    chk("clr_in_ready", bus.in_ready, 1);
    chk("clr_out_addr", 32'(bus.out_addr), 0);
    chk("clr_err_count", bus.err_count, 0);
    @(posedge clk); #1;
  endtask

  task automatic golden(input string nm, input logic [2:0] f, input logic [6:0] op,
                        input logic [4:0] d, s1, s2, input logic [2:0] f3,
                        input logic [31:0] im, input logic [31:0] want);
    clr(1'b0);
    send(f, op, d, s1, s2, f3, 7'd0, im);
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1);
    chk({nm, "_word"}, bus.out_instr, want);
    chk({nm, "_addr"}, 32'(bus.out_addr), 0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] rnd_imm();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 5))
      0: return r;
      1: return {{20{r[11]}}, r[11:0]};
      2: return {{19{r[12]}}, r[12:0]};
      3: return {{19{r[12]}}, r[12:1], 1'b0};
      4: return {{11{r[20]}}, r[20:1], 1'b0};
      default: return {r[31:12], 12'h000};
    endcase
  endfunction

  initial begin
    bus.clear = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
    bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_instr", bus.out_instr, 0);
    chk("rst_out_addr", 32'(bus.out_addr), 0);
    chk("rst_err_pulse", bus.err_pulse, 0);
    chk("rst_err_count", bus.err_count, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    @(posedge clk); @(posedge clk); #1;
    n_rst = 1'b1;
    @(posedge clk); #1;

    golden("I", 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5, 32'h00500093);
    golden("S", 3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 32'd4, 32'h0020A223);
    golden("B", 3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 32'd8, 32'h00000463);
    golden("J", 3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, -32'sd4, 32'hFFDFF06F);

    // Backpressure: third request waits until the consumer frees a slot.
    clr(1'b0);
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h00, 32'd0);
    send(3'd0, 7'h33, 5'd4, 5'd5, 5'd6, 3'd7, 7'h20, 32'd0);
    @(negedge clk);
    chk("bp_full_in_ready", bus.in_ready, 0);
    @(posedge clk); #1;
    fork
      send(3'd4, 7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000);
      begin repeat (3) @(posedge clk); #1; bus.out_ready = 1'b1; end
    join
    repeat (3) @(posedge clk); #1;

    // Rejects back to back, then a legal R still gets the first address.
    clr(1'b0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7);
    send(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd2048);
    send(3'd6, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    chk("rej_err_pulse", bus.err_pulse, 1);
    chk("rej_err_count", bus.err_count, 3);
    chk("rej_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    send(3'd0, 7'h33, 5'd9, 5'd10, 5'd11, 3'd1, 7'h01, 32'd0);
    @(negedge clk);
    chk("rej_r_addr", 32'(bus.out_addr), 0);
    @(posedge clk); #1;

    // Address wrap over 5 words with AW=2, then clear with one entry buffered.
    clr(1'b0);
    for (int i = 0; i < 5; i++) send(3'd1, 7'h13, 5'(i), 5'd1, 5'd0, 3'd0, 7'd0, 32'(i * 3));
    repeat (2) @(posedge clk); #1;
    bus.out_ready = 1'b0;
    send(3'd0, 7'h33, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    clr(1'b1);

    // Async reset with a full FIFO under backpressure.
    send(3'd0, 7'h33, 5'd2, 5'd2, 5'd2, 3'd0, 7'd0, 32'd0);
    send(3'd0, 7'h33, 5'd3, 5'd3, 5'd3, 3'd0, 7'd0, 32'd0);
    #2 n_rst = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    @(negedge clk); @(posedge clk);
    #3 n_rst = 1'b1;
    @(negedge clk);
    chk("arst_in_ready", bus.in_ready, 1);
    @(posedge clk); #1;

    // Randomized traffic with random consumer backpressure.
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [2:0] f;
          f = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
          send(f, 7'($urandom()), 5'($urandom()), 5'($urandom()), 5'($urandom()),
               3'($urandom()), 7'($urandom()), rnd_imm());
        end
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk); #1;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RISC-V RV32I instruction encoder. It packs decoded fields (format, opcode, registers, funct, full 32-bit immediate) into a 32-bit instruction word, swizzling the immediate for each format. It range-checks each immediate and buffers results in a small FIFO with a valid/ready handshake and a running word address. It feeds instruction-memory preload and self-test stimulus, and is the inverse of the core's immediate-generation/decode path.

## Interface
- DEPTH, 2: output FIFO entries (power of two, ≥2).
- AW, 10: width of word address counter.
- BASE_ADDR, 0: address assigned to first emitted instruction after reset/clear.
- clk  in  1  clock, all state on rising edge.
- n_rst  in  1  reset, asynchronous and active-low.
- clear  in  1  sync flush: empty FIFO, address ← BASE_ADDR, err_count ← 0; has priority over push/pop.
- in_valid  in  1  request valid.
- in_ready  out  1  encoder can accept request.
- fmt  in  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6/7 illegal.
- opcode  in  7  placed verbatim in [6:0].
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3; funct7  in  7.
- imm  in  32  signed byte-offset/immediate, unswizzled.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_instr  out  32  encoded word at head.
- out_addr  out  AW  word address of head entry.
- err_pulse  out  1  one-cycle flag: a request was rejected.
- err_count  out  8  rejected requests, saturating at 255.

## Operation
- Encodings, MSB→LSB:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}
  - U: {imm[31:12], rd, opcode}
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}
- Fields not used by a format are ignored.
- Rejection rules:
  - I/S: imm ≠ sign-extension of imm[11:0].
  - B: imm ≠ sign-extension of imm[12:0], or imm[0]=1.
  - J: imm ≠ sign-extension of imm[20:0], or imm[0]=1.
  - U: imm[11:0] ≠ 0.
  - fmt 6/7: always rejected.
  - R: never rejected.
- Accept occurs on in_valid & in_ready.
  - Legal request: encoded word pushed into FIFO.
  - Rejected request: consumed but not pushed; err_pulse and err_count update.
- Address counter: head entry's out_addr = base counter; counter increments by 1 on each pop (out_valid & out_ready) and wraps modulo 2^AW.
- in_ready = (FIFO count < DEPTH). There is no pass-through when full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when not full: count unchanged, both take effect.
- Rejected requests are still accepted only when in_ready=1.

## Timing
- Reset values:
  - out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_count=0.
  - in_ready=1 (FIFO empty).
- Latency: request accepted at edge N → out_valid=1 with its word from just after edge N (1 cycle), if FIFO was empty.
- out_instr/out_addr hold stable while out_valid=1 & out_ready=0.
- err_pulse is high for exactly the cycle after the accepting edge of a rejected request; back-to-back rejects keep it high continuously.
- clear at edge N: after N, out_valid=0, in_ready=1, out_addr=BASE_ADDR, err_count=0. Any request presented in that cycle is dropped, with no error.
- n_rst asserted mid-stream: all state returns to reset values immediately (asynchronous); in-flight entries are lost.
- Outputs are registered or derived from the FIFO count/head only; no combinational path from in_* to out_*.

## Test plan
- Each of these from reset, with out_ready=1 and BASE_ADDR=0:
  - I, opcode 0x13, rd=1, rs1=0, funct3=0, imm=5 → out_instr 0x00500093 at out_addr 0.
  - S, opcode 0x23, rs1=1, rs2=2, funct3=2, imm=4 → 0x0020A223.
  - B, opcode 0x63, rs1=rs2=0, funct3=0, imm=8 → 0x00000463.
  - J, opcode 0x6F, rd=0, imm=−4 → 0xFFDFF06F.
- Backpressure: out_ready=0, push 3 legal requests with DEPTH=2 → in_ready drops after the second accept, and the third is held until a pop. Release out_ready → words appear in order at out_addr 0,1,2.
- Rejects: B with imm=7, then I with imm=2048, then fmt=6 → no out_valid; err_pulse high 3 consecutive cycles; err_count=3. A following legal R request still emits at out_addr 0.
- Wrap and clear: AW=2, emit 5 words → out_addr sequence 0,1,2,3,0. Assert clear with 1 entry buffered → out_valid=0 next cycle, out_addr=BASE_ADDR, err_count=0.
- Async reset: assert n_rst while FIFO is full and out_ready=0 → out_valid falls without a clock edge; in_ready=1 after release.
